// File: rtl/dmem_ctrl.sv
// Data memory controller: clears the array after reset, then serves single-cycle
// byte/word loads and stores with alignment and range checking.
module dmem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  // state   | meaning
  // ST_INIT | clearing the array one word per cycle, requests not accepted
  // ST_IDLE | serving requests, one per cycle

  localparam int B      = DATA_W / 8;
  localparam int LB     = $clog2(B);
  localparam int LD     = $clog2(DEPTH);
  localparam int IDX_HI = LB + LD;
  localparam logic [LD-1:0]     LAST_IDX   = LD'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] RANGE_MASK = ADDR_W'((64'd1 << IDX_HI) - 64'd1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t            state;
  logic [LD-1:0]     sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [LB-1:0]     lane;
  logic [LD-1:0]     word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic              wr_en;
  logic [DATA_W-1:0] word_rd;
  logic [7:0]        byte_rd;
  logic [DATA_W-1:0] rd_data;

  assign lane         = req_addr[LB-1:0];
  assign word_idx     = req_addr[IDX_HI-1:LB];
  assign misaligned   = req_size && (lane != '0);
  assign out_of_range = |(req_addr & ~RANGE_MASK);
  assign req_err      = misaligned || out_of_range;
  assign accept       = req_valid && req_ready;
  assign wr_en        = accept && req_we && !req_err;
  assign word_rd      = mem[word_idx];

  // Select the addressed byte lane of the current word.
  always_comb begin
    byte_rd = '0;
    for (int l = 0; l < B; l++) begin
      if (lane == LB'(l)) byte_rd = word_rd[l*8 +: 8];
    end
  end

  // Byte reads are zero- or sign-extended; word reads pass straight through.
  always_comb begin
    rd_data = '0;
    if (req_size) rd_data = word_rd;
    else          rd_data = {{(DATA_W-8){req_signed & byte_rd[7]}}, byte_rd};
  end

  // Array: swept to zero during INIT, then lane-masked writes. No reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep_cnt] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < B; l++) begin
        if (req_size)               mem[word_idx][l*8 +: 8] <= req_wdata[l*8 +: 8];
        else if (lane == LB'(l))    mem[word_idx][l*8 +: 8] <= req_wdata[7:0];
      end
    end
  end

  // Sequencer and registered response; the response is computed from the
  // array contents before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && req_err;
      rsp_rdata <= (accept && !req_we && !req_err) ? rd_data : '0;
      case (state)
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + LD'(1);
          if (sweep_cnt == LAST_IDX) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          req_ready <= 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, hand-written reset
// and back-to-back sequences, and random traffic against a byte-array model.
module tb_dmem_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;
  localparam int NBYTES = DEPTH * (DATA_W / 8);

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  dmem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference memory as little-endian bytes.
  logic [7:0] bytes [NBYTES];

  typedef struct {
    logic        we;
    logic        size;
    logic        sgn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NBYTES; i++) bytes[i] = 8'h00;
  endfunction

  function automatic void model(input logic we, input logic size, input logic sgn,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                output logic err, output logic [15:0] rdata);
    int a;
    a = int'(addr);
    err = (a >= NBYTES) || (size && (a % 2 != 0));
    rdata = 16'h0000;
    if (!err) begin
      if (we) begin
        bytes[a] = wdata[7:0];
        if (size) bytes[a+1] = wdata[15:8];
      end else if (size) begin
        rdata = {bytes[a+1], bytes[a]};
      end else begin
        rdata = {{8{sgn & bytes[a][7]}}, bytes[a]};
      end
    end
  endfunction

  // Counts edges until init_done, starting from n0 edges already elapsed since release.
  task automatic wait_init(input string tag, input int n0);
    int n;
    bit early;
    bit saw_rsp;
    n = n0;
    early = 0;
    saw_rsp = 0;
    while (!init_done && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (req_ready && !init_done) early = 1;
      if (rsp_valid) saw_rsp = 1;
    end
    chk({tag, "_sweep_len"}, n, DEPTH);
    chk({tag, "_ready_after"}, req_ready, 1'b1);
    chk({tag, "_ready_early"}, early, 1'b0);
    chk({tag, "_rsp_in_sweep"}, saw_rsp, 1'b0);
  endtask

  // One isolated request; called one time unit after a rising edge.
  task automatic single(input string name, input logic we, input logic size, input logic sgn,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic exp_err, input logic [15:0] exp_rd);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, "_valid"}, rsp_valid, 1'b1);
    chk({name, "_err"}, rsp_err, exp_err);
    chk({name, "_rdata"}, rsp_rdata, exp_rd);
    @(posedge clk); #1;
    chk({name, "_valid_drop"}, rsp_valid, 1'b0);
    chk({name, "_idle_zero"}, {rsp_err, rsp_rdata}, 17'h0);
  endtask

  initial begin
    logic        m_err;
    logic [15:0] m_rd;
    bit          saw;

    vecs[0]  = '{0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000};
    vecs[1]  = '{0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000};
    vecs[2]  = '{1, 1, 0, 16'h0004, 16'hBEEF, 0, 16'h0000};
    vecs[3]  = '{1, 0, 0, 16'h0005, 16'hAB12, 0, 16'h0000};
    vecs[4]  = '{0, 1, 0, 16'h0004, 16'h0000, 0, 16'h12EF};
    vecs[5]  = '{0, 0, 1, 16'h0004, 16'h0000, 0, 16'hFFEF};
    vecs[6]  = '{0, 0, 0, 16'h0004, 16'h0000, 0, 16'h00EF};
    vecs[7]  = '{0, 0, 1, 16'h0005, 16'h0000, 0, 16'h0012};
    vecs[8]  = '{1, 1, 0, 16'h0003, 16'hAAAA, 1, 16'h0000};
    vecs[9]  = '{0, 1, 0, 16'h0002, 16'h0000, 0, 16'h0000};
    vecs[10] = '{0, 1, 0, 16'h0200, 16'h0000, 1, 16'h0000};
    vecs[11] = '{1, 0, 0, 16'h0201, 16'h00CC, 1, 16'h0000};
    vecs[12] = '{0, 0, 0, 16'h8001, 16'h0000, 1, 16'h0000};
    vecs[13] = '{1, 1, 0, 16'h01FE, 16'h8081, 0, 16'h0000};
    vecs[14] = '{0, 0, 1, 16'h01FF, 16'h0000, 0, 16'hFF80};
    vecs[15] = '{0, 0, 1, 16'h01FE, 16'h0000, 0, 16'hFF81};
    vecs[16] = '{0, 0, 0, 16'h01FF, 16'h0000, 0, 16'h0080};
    vecs[17] = '{0, 1, 0, 16'h0005, 16'h0000, 1, 16'h0000};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    model_clear();
    #23;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_zero", {rsp_err, rsp_rdata}, 17'h0);

    // Release reset and push a write at word 0 during the sweep; it must be ignored.
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_addr = 16'h0000; req_wdata = 16'h1234;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1;
    end
    req_valid = 1'b0;
    chk("init_req_ignored", saw, 1'b0);
    wait_init("init", 30);

    for (int i = 0; i < 18; i++) begin
      single($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn,
             vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rd);
      model(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, m_err, m_rd);
    end

    // Back-to-back: write, read-after-write, byte write, read.
    begin
      logic        bw [4]   = '{1, 0, 1, 0};
      logic        bs [4]   = '{1, 1, 0, 1};
      logic [15:0] ba [4]   = '{16'h0008, 16'h0008, 16'h0009, 16'h0008};
      logic [15:0] bd [4]   = '{16'h5555, 16'h0000, 16'h0077, 16'h0000};
      logic [15:0] bexp [4] = '{16'h0000, 16'h5555, 16'h0000, 16'h7755};
      for (int i = 0; i < 4; i++) begin
        req_valid = 1'b1; req_we = bw[i]; req_size = bs[i]; req_signed = 1'b0;
        req_addr = ba[i]; req_wdata = bd[i];
        model(bw[i], bs[i], 1'b0, ba[i], bd[i], m_err, m_rd);
        @(posedge clk); #1;
        chk($sformatf("b2b%0d_valid", i), rsp_valid, 1'b1);
        chk($sformatf("b2b%0d_rdata", i), rsp_rdata, bexp[i]);
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_drop", rsp_valid, 1'b0);
    end

    // Random traffic against the byte-array model.
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic        e_err;
      logic [15:0] e_rd;
      v = ($urandom_range(0, 3) != 0);
      chk("rand_ready", req_ready, 1'b1);
      req_valid = v;
      req_we = 1'($urandom_range(0, 1));
      req_size = 1'($urandom_range(0, 1));
      req_signed = 1'($urandom_range(0, 1));
      req_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      req_wdata = 16'($urandom);
      e_err = 1'b0; e_rd = 16'h0000;
      if (v) model(req_we, req_size, req_signed, req_addr, req_wdata, e_err, e_rd);
      @(posedge clk); #1;
      chk("rand_valid", rsp_valid, v);
      chk("rand_err", rsp_err, e_err);
      chk("rand_rdata", rsp_rdata, e_rd);
    end
    req_valid = 1'b0;

    // Reset in the middle of a sweep.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midsweep_init_done", init_done, 1'b0);
    chk("midsweep_ready", req_ready, 1'b0);
    chk("midsweep_rsp", rsp_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    wait_init("midsweep", 0);
    model_clear();
    single("after_midsweep_rd4", 0, 1, 0, 16'h0004, 16'h0000, 0, 16'h0000);
    single("after_midsweep_rd8", 0, 1, 0, 16'h0008, 16'h0000, 0, 16'h0000);

    // Reset while a read is being presented: no response for it.
    single("pend_wr", 1, 1, 0, 16'h0010, 16'h1111, 0, 16'h0000);
    single("pend_chk", 0, 1, 0, 16'h0010, 16'h0000, 0, 16'h1111);
    req_valid = 1'b1; req_we = 1'b0; req_size = 1'b1; req_addr = 16'h0010;
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("pend_ready_low", req_ready, 1'b0);
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1;
    end
    req_valid = 1'b0;
    chk("pend_no_rsp", saw, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    wait_init("pend", 0);
    single("pend_cleared", 0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
